sequence_key_checker: RTL and testbench
=======================================

// Module: sequence_key_checker
// PURPOSE
// - Consumer of the 16-bit sequence key produced by the key builder. Latches the key on its transmit strobe,
//   then accepts player digit entries one cell at a time and compares each entry against the stored key.
// - Reports solved, strike and exploded status to the game controller.
// - Sits between the key builder, the debounced/one-pulsed keypad input and the game state machine.
// PARAMETERS
// NUM_CELLS      4         number of 4-bit cells in the key (key width = NUM_CELLS*CELL_W)
// CELL_W         4         bits per cell / per entered digit
// MAX_STRIKES    3         mismatches (incl. timeouts) before exploded
// TIMEOUT_CYC    50000000  cycles with no digit in ENTRY before a timeout strike
// PORTS
// clk            in   1    system clock
// rst            in   1    asynchronous, active-low reset
// enable         in   1    level; 0 forces IDLE
// sequence_key   in   16   key from builder; cell0 = [15:12] entered first, cell3 = [3:0] entered last
// transmit       in   1    one-cycle strobe: sequence_key is valid this cycle
// digit_in       in   4    player digit
// digit_valid    in   1    one-cycle strobe: digit_in is valid this cycle
// solved         out  1    level: full key entered correctly
// exploded       out  1    level: strike limit reached
// strike_pulse   out  1    one-cycle pulse per mismatch or timeout
// strikes        out  2    accumulated strike count ($clog2(MAX_STRIKES+1) bits)
// cell_index     out  2    index of next cell expected (progress for display)
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; key_reg, cell_index, strikes and timer cleared; all outputs 0.
// - States: IDLE, ENTRY, PASS, FAIL. All outputs registered; a decision is visible 1 cycle after the strobe.
// - IDLE: enable=1 && transmit -> key_reg<=sequence_key, cell_index<=0, timer reload -> ENTRY.
//   digit_valid is ignored in IDLE.
// - ENTRY, on digit_valid:
//   - digit_in==key_reg cell[cell_index] && cell_index==NUM_CELLS-1 -> solved<=1 -> PASS.
//   - digit_in==key_reg cell[cell_index], otherwise -> cell_index+1, timer reload.
//   - mismatch -> strike_pulse, strikes+1, cell_index<=0, timer reload;
//     if strikes+1==MAX_STRIKES, exploded<=1 -> FAIL.
// - ENTRY timeout: timer reaches 0 with no digit_valid -> handled as a mismatch, same rules.
// - digit_valid and timer expiry in the same cycle: the digit is processed and the timeout is discarded.
// - transmit while in ENTRY: ignored; the key stays locked until PASS/FAIL/IDLE.
// - PASS: solved held at 1.
//   - enable=1 && transmit -> load new key, solved<=0, cell_index<=0 -> ENTRY; strikes retained across levels.
// - FAIL: exploded held at 1. All inputs except enable are ignored.
// - enable=0 in any state -> IDLE next cycle; solved, exploded, strikes and cell_index cleared.
// - strikes saturates at MAX_STRIKES; cell_index never exceeds NUM_CELLS-1.
// - Timer runs only in ENTRY; it is a down counter from TIMEOUT_CYC-1, width $clog2(TIMEOUT_CYC).
// STRUCTURE
// - Package seq_key_pkg: state encodings, NUM_CELLS, CELL_W, KEY_W, and function get_cell(key, idx)
//   returning the CELL_W slice, MSB cell first. Shared with the key builder.
// - Sub-module inactivity_timer: load / run / expired, parameterised by TIMEOUT_CYC.
// - The top holds the FSM, key register, index and strike counters.
// TESTING (benches use TIMEOUT_CYC=20)
// 1. Reset, enable=1, transmit with key 16'h3A7C; digits 3,A,7,C
//    -> cell_index 0,1,2,3; solved=1 one cycle after C; strikes=0.
// 2. Key 16'h1234; digits 1,5
//    -> strike_pulse once, strikes=1, cell_index=0; then 1,2,3,4 -> solved=1.
// 3. Key 16'h0000; wrong digit F three times -> strikes 1,2,3; exploded=1 after the third;
//    a further transmit or digit leaves exploded=1.
// 4. Key 16'h5555; no digits for 20 cycles -> strike_pulse on expiry, strikes=1.
//    A digit on the expiry cycle -> only the digit is counted.
// 5. Mid-entry (cell_index=2): enable=0 -> IDLE next cycle with all outputs 0.
//    Async rst=0 mid-entry -> outputs 0 immediately, without waiting for clk.
// 6. In PASS with strikes=1: transmit key 16'hBEEF -> solved=0, ENTRY, strikes still 1;
//    transmit during ENTRY leaves key_reg unchanged.

Source files
------------

// File: rtl/seq_key_pkg.sv
// Shared definitions for the sequence key builder/checker pair: key geometry,
// checker state encoding and the cell-slicing helper.
package seq_key_pkg;

    localparam int NUM_CELLS = 4;
    localparam int CELL_W    = 4;
    localparam int KEY_W     = NUM_CELLS * CELL_W;
    localparam int IDX_W     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    // Cell 0 occupies the most significant nibble and is entered first.
    function automatic logic [CELL_W-1:0] get_cell(input logic [KEY_W-1:0] key,
                                                   input logic [IDX_W-1:0] idx);
        return key[KEY_W-1-int'(idx)*CELL_W -: CELL_W];
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Down counter that flags expiry after TIMEOUT_CYC running cycles without a reload.
module inactivity_timer #(
    parameter  int TIMEOUT_CYC = 50000000,
    localparam int CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (run && count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign expired = run && (count_reg == '0);

endmodule

// File: rtl/sequence_key_checker.sv
// Locks a sequence key on transmit, compares player digits cell by cell and
// tracks solved / strike / exploded status for the game controller.
module sequence_key_checker
    import seq_key_pkg::*;
#(
    parameter  int MAX_STRIKES = 3,
    parameter  int TIMEOUT_CYC = 50000000,
    localparam int STRIKE_W    = $clog2(MAX_STRIKES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [KEY_W-1:0]    sequence_key,
    input  logic                transmit,
    input  logic [CELL_W-1:0]   digit_in,
    input  logic                digit_valid,
    output logic                solved,
    output logic                exploded,
    output logic                strike_pulse,
    output logic [STRIKE_W-1:0] strikes,
    output logic [IDX_W-1:0]    cell_index
);

    state_t               state_reg, state_next;
    logic [KEY_W-1:0]     key_reg, key_next;
    logic [IDX_W-1:0]     cell_index_reg, cell_index_next;
    logic [STRIKE_W-1:0]  strikes_reg, strikes_next;
    logic                 solved_reg, solved_next;
    logic                 exploded_reg, exploded_next;
    logic                 strike_pulse_reg, strike_pulse_next;

    logic match, last_cell, hit, miss, strike_limit;
    logic timer_load, timer_run, timer_expired;

    inactivity_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .run     (timer_run),
        .expired (timer_expired)
    );

    // A digit on the expiry cycle wins; the timeout is only a miss when no digit arrives.
    assign match        = (digit_in == get_cell(key_reg, cell_index_reg));
    assign last_cell    = (cell_index_reg == IDX_W'(NUM_CELLS - 1));
    assign hit          = digit_valid && match;
    assign miss         = digit_valid ? !match : timer_expired;
    assign strike_limit = (int'(strikes_reg) + 1) >= MAX_STRIKES;
    assign timer_run    = (state_reg == ST_ENTRY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_PASS: if (transmit) state_next = ST_ENTRY;
                ST_ENTRY: begin
                    if (hit && last_cell)         state_next = ST_PASS;
                    else if (miss && strike_limit) state_next = ST_FAIL;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        key_next          = key_reg;
        cell_index_next   = cell_index_reg;
        strikes_next      = strikes_reg;
        solved_next       = solved_reg;
        exploded_next     = exploded_reg;
        strike_pulse_next = 1'b0;
        timer_load        = 1'b0;
        if (!enable) begin
            cell_index_next = '0;
            strikes_next    = '0;
            solved_next     = 1'b0;
            exploded_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_PASS: begin
                    if (transmit) begin
                        key_next        = sequence_key;
                        cell_index_next = '0;
                        solved_next     = 1'b0;
                        timer_load      = 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (hit) begin
                        if (last_cell) begin
                            solved_next = 1'b1;
                        end else begin
                            cell_index_next = cell_index_reg + IDX_W'(1);
                            timer_load      = 1'b1;
                        end
                    end else if (miss) begin
                        strike_pulse_next = 1'b1;
                        cell_index_next   = '0;
                        timer_load        = 1'b1;
                        if (strikes_reg != STRIKE_W'(MAX_STRIKES))
                            strikes_next = strikes_reg + STRIKE_W'(1);
                        if (strike_limit)
                            exploded_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg          <= '0;
            cell_index_reg   <= '0;
            strikes_reg      <= '0;
            solved_reg       <= 1'b0;
            exploded_reg     <= 1'b0;
            strike_pulse_reg <= 1'b0;
        end else begin
            key_reg          <= key_next;
            cell_index_reg   <= cell_index_next;
            strikes_reg      <= strikes_next;
            solved_reg       <= solved_next;
            exploded_reg     <= exploded_next;
            strike_pulse_reg <= strike_pulse_next;
        end
    end

    assign solved       = solved_reg;
    assign exploded     = exploded_reg;
    assign strike_pulse = strike_pulse_reg;
    assign strikes      = strikes_reg;
    assign cell_index   = cell_index_reg;

endmodule

// File: tb/tb_sequence_key_checker.sv
// Directed bench for sequence_key_checker with a 20-cycle inactivity timeout.
module tb_sequence_key_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sequence_key = '0;
    logic        transmit = 1'b0;
    logic [3:0]  digit_in = '0;
    logic        digit_valid = 1'b0;
    logic        solved, exploded, strike_pulse;
    logic [1:0]  strikes, cell_index;

    int total = 0;
    int bad   = 0;

    sequence_key_checker #(.MAX_STRIKES(3), .TIMEOUT_CYC(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sequence_key (sequence_key),
        .transmit     (transmit),
        .digit_in     (digit_in),
        .digit_valid  (digit_valid),
        .solved       (solved),
        .exploded     (exploded),
        .strike_pulse (strike_pulse),
        .strikes      (strikes),
        .cell_index   (cell_index)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on negedge; after one posedge the registered outputs are sampled here.
    task automatic xmit(input logic [15:0] key);
        sequence_key = key;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        $display("xmit key=%h -> solved=%0b exploded=%0b strikes=%0d idx=%0d",
                 key, solved, exploded, strikes, cell_index);
    endtask

    task automatic digit(input logic [3:0] d);
        digit_in = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        $display("digit %h -> solved=%0b exploded=%0b pulse=%0b strikes=%0d idx=%0d",
                 d, solved, exploded, strike_pulse, strikes, cell_index);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_solved"},   32'(solved),       32'd0);
        check_val({tag, "_exploded"}, 32'(exploded),     32'd0);
        check_val({tag, "_pulse"},    32'(strike_pulse), 32'd0);
        check_val({tag, "_strikes"},  32'(strikes),      32'd0);
        check_val({tag, "_idx"},      32'(cell_index),   32'd0);
    endtask

    initial begin
        // Reset state
        idle_cycles(2);
        check_all_zero("reset");
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Correct entry of 3A7C
        xmit(16'h3A7C);
        check_val("t1_idx0", 32'(cell_index), 32'd0);
        digit(4'h3); check_val("t1_idx1", 32'(cell_index), 32'd1);
        digit(4'hA); check_val("t1_idx2", 32'(cell_index), 32'd2);
        digit(4'h7); check_val("t1_idx3", 32'(cell_index), 32'd3);
        check_val("t1_not_solved_yet", 32'(solved), 32'd0);
        digit(4'hC);
        check_val("t1_solved", 32'(solved), 32'd1);
        check_val("t1_strikes", 32'(strikes), 32'd0);

        // Mismatch on second cell, then full correct entry
        xmit(16'h1234);
        check_val("t2_solved_cleared", 32'(solved), 32'd0);
        digit(4'h1);
        digit(4'h5);
        check_val("t2_pulse", 32'(strike_pulse), 32'd1);
        check_val("t2_strikes", 32'(strikes), 32'd1);
        check_val("t2_idx_reset", 32'(cell_index), 32'd0);
        digit(4'h1);
        check_val("t2_pulse_once", 32'(strike_pulse), 32'd0);
        digit(4'h2); digit(4'h3); digit(4'h4);
        check_val("t2_solved", 32'(solved), 32'd1);

        // New level from PASS keeps strikes; transmit during ENTRY is ignored
        xmit(16'hBEEF);
        check_val("t6_solved_cleared", 32'(solved), 32'd0);
        check_val("t6_strikes_kept", 32'(strikes), 32'd1);
        xmit(16'h0000);
        digit(4'hB);
        check_val("t6_key_locked", 32'(cell_index), 32'd1);
        digit(4'hE); digit(4'hE); digit(4'hF);
        check_val("t6_solved", 32'(solved), 32'd1);
        check_val("t6_strikes", 32'(strikes), 32'd1);

        // Disable clears everything, then explode on three wrong digits
        enable = 1'b0;
        @(negedge clk);
        check_all_zero("disable_pass");
        enable = 1'b1;
        xmit(16'h0000);
        digit(4'hF); check_val("t3_strikes1", 32'(strikes), 32'd1);
        digit(4'hF); check_val("t3_strikes2", 32'(strikes), 32'd2);
        check_val("t3_not_exploded", 32'(exploded), 32'd0);
        digit(4'hF);
        check_val("t3_strikes3", 32'(strikes), 32'd3);
        check_val("t3_exploded", 32'(exploded), 32'd1);
        xmit(16'h1111);
        check_val("t3_exploded_xmit", 32'(exploded), 32'd1);
        digit(4'h0);
        check_val("t3_exploded_digit", 32'(exploded), 32'd1);
        check_val("t3_no_pulse", 32'(strike_pulse), 32'd0);
        check_val("t3_strikes_sat", 32'(strikes), 32'd3);

        // Timeout strike exactly 20 cycles after the key is latched
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        xmit(16'h5555);
        idle_cycles(19);
        check_val("t4_no_early_pulse", 32'(strike_pulse), 32'd0);
        check_val("t4_no_early_strike", 32'(strikes), 32'd0);
        @(negedge clk);
        check_val("t4_timeout_pulse", 32'(strike_pulse), 32'd1);
        check_val("t4_timeout_strikes", 32'(strikes), 32'd1);
        // Digit on the next expiry cycle: only the digit counts
        idle_cycles(19);
        digit(4'h5);
        check_val("t4_digit_wins_pulse", 32'(strike_pulse), 32'd0);
        check_val("t4_digit_wins_strikes", 32'(strikes), 32'd1);
        check_val("t4_digit_wins_idx", 32'(cell_index), 32'd1);

        // Mid-entry disable
        digit(4'h5);
        check_val("t5_idx2", 32'(cell_index), 32'd2);
        enable = 1'b0;
        @(negedge clk);
        check_all_zero("t5_disable");

        // Mid-entry asynchronous reset
        enable = 1'b1;
        xmit(16'h3A7C);
        digit(4'hF);
        digit(4'h3);
        digit(4'hA);
        check_val("t5_pre_rst_idx", 32'(cell_index), 32'd2);
        check_val("t5_pre_rst_strikes", 32'(strikes), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("t5_async_rst");
        @(negedge clk);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
